// File: rtl/uart_pkg.sv
// Shared types and constants for the UART message framer.
package uart_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHECK,
    READY
  } msg_state_t;

endpackage

// File: rtl/uart_msg_ctrl_if.sv
// Byte-stream input, message read port and status outputs of the message framer.
interface uart_msg_ctrl_if #(
  parameter int unsigned LEN_BITS = 5
) ();

  logic [7:0]          in_data;
  logic                in_valid;
  logic                msg_valid;
  logic [LEN_BITS-1:0] msg_len;
  logic [LEN_BITS-1:0] rd_addr;
  logic [7:0]          rd_data;
  logic                msg_ack;
  logic                err_chk;
  logic                err_len;
  logic                err_timeout;
  logic [7:0]          drop_count;

  // Byte source / message consumer side.
  modport master (
    output in_data, in_valid, rd_addr, msg_ack,
    input  msg_valid, msg_len, rd_data, err_chk, err_len, err_timeout, drop_count
  );

  // Framer side.
  modport slave (
    input  in_data, in_valid, rd_addr, msg_ack,
    output msg_valid, msg_len, rd_data, err_chk, err_len, err_timeout, drop_count
  );

endinterface

// File: rtl/uart_msg_buf.sv
// Payload storage: one synchronous write port, one asynchronous read port, no reset.
module uart_msg_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_msg_ctrl.sv
// Frames SYNC/LEN/payload/CHK byte streams into checked messages held for a consumer.
module uart_msg_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 4096,
  parameter logic [7:0]  SYNC    = SYNC_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  uart_msg_ctrl_if.slave bus
);

  localparam int unsigned LEN_BITS = $clog2(MAX_LEN + 1);
  localparam int unsigned AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH    = 1 << AW;
  localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  msg_state_t          state_q;
  logic                valid_q;
  logic [TW-1:0]       timer_q;
  logic [AW-1:0]       idx_q;
  logic [LEN_BITS-1:0] len_q;
  logic [7:0]          sum_q;
  logic                msg_valid_q;
  logic [LEN_BITS-1:0] msg_len_q;
  logic                err_chk_q;
  logic                err_len_q;
  logic                err_timeout_q;
  logic [7:0]          drop_q;

  logic accept;
  logic len_bad;
  logic timer_expired;
  logic last_payload;
  logic chk_ok;
  logic buf_we;

  // One accept per in_valid high period, on its rising edge.
  assign accept        = bus.in_valid & ~valid_q;
  assign len_bad       = (bus.in_data == 8'd0) || (32'(bus.in_data) > MAX_LEN);
  assign timer_expired = (timer_q == TW'(TIMEOUT - 1));
  assign last_payload  = ((LEN_BITS'(idx_q) + LEN_BITS'(1)) == len_q);
  assign chk_ok        = ((sum_q + bus.in_data) == 8'h00);
  assign buf_we        = accept && (state_q == PAYLOAD);

  uart_msg_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (bus.in_data),
    .raddr (bus.rd_addr[AW-1:0]),
    .rdata (bus.rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      valid_q       <= 1'b0;
      timer_q       <= '0;
      idx_q         <= '0;
      len_q         <= '0;
      sum_q         <= '0;
      msg_valid_q   <= 1'b0;
      msg_len_q     <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      valid_q       <= bus.in_valid;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (accept && (bus.in_data == SYNC)) begin
            state_q <= LEN;
            timer_q <= '0;
          end
        end

        LEN: begin
          if (accept) begin
            timer_q <= '0;
            if (len_bad) begin
              state_q   <= IDLE;
              err_len_q <= 1'b1;
            end else begin
              state_q <= PAYLOAD;
              len_q   <= LEN_BITS'(bus.in_data);
              sum_q   <= bus.in_data;
              idx_q   <= '0;
            end
          end else if (timer_expired) begin
            state_q       <= IDLE;
            err_timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        PAYLOAD: begin
          if (accept) begin
            timer_q <= '0;
            sum_q   <= sum_q + bus.in_data;
            idx_q   <= idx_q + AW'(1);
            if (last_payload) begin
              state_q <= CHECK;
            end
          end else if (timer_expired) begin
            state_q       <= IDLE;
            err_timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        CHECK: begin
          if (accept) begin
            timer_q <= '0;
            if (chk_ok) begin
              state_q     <= READY;
              msg_valid_q <= 1'b1;
              msg_len_q   <= len_q;
            end else begin
              state_q   <= IDLE;
              err_chk_q <= 1'b1;
            end
          end else if (timer_expired) begin
            state_q       <= IDLE;
            err_timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        READY: begin
          // Buffer stays frozen; late bytes are only counted.
          if (accept && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
          end
          if (bus.msg_ack) begin
            state_q     <= IDLE;
            msg_valid_q <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.msg_valid   = msg_valid_q;
  assign bus.msg_len     = msg_len_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.drop_count  = drop_q;

endmodule

// File: tb/tb_uart_msg_ctrl.sv
// Randomized bench for uart_msg_ctrl against a frame-level reference model.
module tb_uart_msg_ctrl;

  localparam int unsigned MAX_LEN  = 16;
  localparam int unsigned TIMEOUT  = 4096;
  localparam int unsigned LEN_BITS = 5;
  localparam logic [7:0]  SYNC     = 8'hA5;

  logic clk;
  logic rst_n;

  uart_msg_ctrl_if #(.LEN_BITS(LEN_BITS)) bus ();

  uart_msg_ctrl #(
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT),
    .SYNC    (SYNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: collects the bytes of the current frame and judges it when complete.
  bit         m_prev_v;
  bit         m_held;
  logic [7:0] m_frame[$];
  int         m_idle;
  logic [7:0] m_payload[MAX_LEN];
  int         m_len;
  int         m_drop;
  bit         m_err_chk, m_err_len, m_err_to;

  task automatic model_reset();
    m_prev_v = 0;
    m_held   = 0;
    m_frame.delete();
    m_idle   = 0;
    m_len    = 0;
    m_drop   = 0;
    m_err_chk = 0; m_err_len = 0; m_err_to = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit ack);
    bit acc;
    int sum;
    acc = v && !m_prev_v;
    m_prev_v = v;
    m_err_chk = 0; m_err_len = 0; m_err_to = 0;
    if (m_held) begin
      if (acc && m_drop < 255) m_drop++;
      if (ack) m_held = 0;
    end else if (m_frame.size() > 0) begin
      if (acc) begin
        m_frame.push_back(d);
        m_idle = 0;
        if (m_frame.size() == 2) begin
          if (d == 0 || d > MAX_LEN) begin
            m_err_len = 1;
            m_frame.delete();
          end
        end else if (m_frame.size() == int'(m_frame[1]) + 3) begin
          sum = 0;
          for (int i = 1; i < m_frame.size(); i++) sum += int'(m_frame[i]);
          if (sum % 256 == 0) begin
            m_held = 1;
            m_len  = int'(m_frame[1]);
            for (int i = 0; i < m_len; i++) m_payload[i] = m_frame[2 + i];
          end else begin
            m_err_chk = 1;
          end
          m_frame.delete();
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_err_to = 1;
          m_frame.delete();
        end
      end
    end else if (acc && d == SYNC) begin
      m_frame.push_back(d);
      m_idle = 0;
    end
  endtask

  // Drive one clock of inputs from the falling edge, then compare after the next rising edge.
  task automatic step(input bit v, input logic [7:0] d, input bit ack);
    int addr;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.msg_ack  = ack;
    model_step(v, d, ack);
    addr = (m_held && m_len > 0) ? int'($urandom_range(m_len - 1)) : int'($urandom_range(31));
    bus.rd_addr = LEN_BITS'(addr);
    @(posedge clk);
    @(negedge clk);
    check("msg_valid", bus.msg_valid, m_held);
    check("err_chk", bus.err_chk, m_err_chk);
    check("err_len", bus.err_len, m_err_len);
    check("err_timeout", bus.err_timeout, m_err_to);
    check("drop_count", bus.drop_count, m_drop);
    if (m_held) begin
      check("msg_len", bus.msg_len, m_len);
      check("rd_data", bus.rd_data, m_payload[addr]);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int hold);
    repeat (hold) step(1, d, 0);
    step(0, d, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 8'h00, 0);
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$], input bit good,
                            input int hold);
    logic [7:0] sum;
    sum = len;
    send_byte(SYNC, hold);
    send_byte(len, hold);
    foreach (pl[i]) begin
      sum = sum + pl[i];
      send_byte(pl[i], hold);
    end
    send_byte(good ? (8'h00 - sum) : (8'h01 - sum), hold);
  endtask

  task automatic check_rd(input int addr, input logic [7:0] exp);
    bus.rd_addr = LEN_BITS'(addr);
    #1;
    check("rd_direct", bus.rd_data, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.msg_valid, 0);
    check({tag, "_len"}, bus.msg_len, 0);
    check({tag, "_chk"}, bus.err_chk, 0);
    check({tag, "_errlen"}, bus.err_len, 0);
    check({tag, "_to"}, bus.err_timeout, 0);
    check({tag, "_drop"}, bus.drop_count, 0);
  endtask

  initial begin
    logic [7:0] pl[$];
    int n;
    int kind;
    int hold;

    rst_n = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.msg_ack = 0; bus.rd_addr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;

    // Basic good frame, then read-back and release.
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'd3, pl, 1, 1);
    check("t1_valid", bus.msg_valid, 1);
    check("t1_len", bus.msg_len, 3);
    check_rd(0, 8'h11); check_rd(1, 8'h22); check_rd(2, 8'h33);
    step(0, 8'h00, 1);
    check("t1_ack", bus.msg_valid, 0);

    // Bad checksum, then a good frame is still taken.
    send_frame(8'd3, pl, 0, 1);
    check("t2_novalid", bus.msg_valid, 0);
    send_frame(8'd3, pl, 1, 2);
    check("t2_valid", bus.msg_valid, 1);
    step(0, 8'h00, 1);

    // Length bounds.
    send_byte(SYNC, 1); send_byte(8'h00, 1);
    send_byte(SYNC, 1); send_byte(8'h11, 1);
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
    send_frame(8'd16, pl, 1, 1);
    check("t3_len16", bus.msg_len, 16);
    step(0, 8'h00, 1);

    // Timeout after silence, then a byte arriving just inside the window.
    send_byte(SYNC, 1); send_byte(8'h02, 1); send_byte(8'hAA, 1);
    idle(TIMEOUT + 4);
    send_byte(SYNC, 1); send_byte(8'h02, 1); send_byte(8'hAA, 1);
    idle(TIMEOUT - 3);
    send_byte(8'hBB, 1); send_byte(8'h99, 1);
    check("t4_inwindow", bus.msg_valid, 1);
    step(0, 8'h00, 1);

    // Stretched valid pulses.
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'd3, pl, 1, 4);
    check("t5_len", bus.msg_len, 3);
    check_rd(1, 8'h22);
    step(0, 8'h00, 1);

    // Drop saturation, ack, then reset mid-payload.
    send_frame(8'd3, pl, 1, 1);
    for (int i = 0; i < 300; i++) send_byte(8'($urandom), 1);
    check("t6_drop", bus.drop_count, 255);
    check_rd(2, 8'h33);
    step(0, 8'h00, 1);
    check("t6_ack", bus.msg_valid, 0);
    send_byte(SYNC, 1); send_byte(8'h05, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
    rst_n = 0;
    bus.in_valid = 0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // Random traffic: good/bad frames, noise, stretched bytes, drops and acks.
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(9);
      hold = $urandom_range(1, 4);
      if ($urandom_range(3) == 0) send_byte(8'($urandom), hold);
      if (kind == 0) begin
        send_byte(SYNC, hold);
        send_byte($urandom_range(1) ? 8'h00 : 8'($urandom_range(17, 255)), hold);
      end else begin
        n = $urandom_range(1, MAX_LEN);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
        send_frame(8'(n), pl, kind > 2, hold);
      end
      idle($urandom_range(3));
      if (m_held) begin
        repeat ($urandom_range(3)) send_byte(8'($urandom), $urandom_range(1, 3));
        if ($urandom_range(1) == 1) begin
          step(1, 8'($urandom), 1);
          step(0, 8'h00, 0);
        end else begin
          step(0, 8'h00, 1);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
